// File: rtl/control_pc_unit.sv
// Single-cycle control decoder and program-counter datapath for a 13-bit word-addressed core.
// Decode is purely combinational; the only state is the PC register.
module control_pc_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero_flag,
    input  logic [12:0] rs_data,
    output logic [12:0] pc,
    output logic [12:0] pc_plus1,
    output logic [12:0] branch_target,
    output logic [12:0] next_pc,
    output logic [3:0]  alu_control,
    output logic        alu_src,
    output logic        reg_dst,
    output logic        mem_write,
    output logic        mem_read,
    output logic        beq,
    output logic        bne,
    output logic        jump,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        jr,
    output logic        jal,
    output logic        sign_ext
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    logic [5:0]         op;
    logic [5:0]         funct;
    logic signed [12:0] imm13;
    logic               take_branch;
    logic               unused_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    // Sign and zero extension agree on the low 13 bits, so one immediate serves both.
    assign imm13 = $signed(instr[12:0]);
    assign unused_bits = ^{instr[25:13], instr[11:6]};

    always_comb begin
        alu_control = ALU_ADD;
        alu_src     = 1'b0;
        reg_dst     = 1'b0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        beq         = 1'b0;
        bne         = 1'b0;
        jump        = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        jr          = 1'b0;
        jal         = 1'b0;
        sign_ext    = 1'b0;

        case (op)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    jr = 1'b1;
                end else begin
                    // Unknown functs stay a full NOP; only recognised ones write rd.
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    case (funct)
                        FN_ADD:  alu_control = ALU_ADD;
                        FN_SUB:  alu_control = ALU_SUB;
                        FN_AND:  alu_control = ALU_AND;
                        FN_OR:   alu_control = ALU_OR;
                        FN_NOR:  alu_control = ALU_NOR;
                        FN_SLT:  alu_control = ALU_SLT;
                        FN_SLL:  alu_control = ALU_SLL;
                        FN_SRL:  alu_control = ALU_SRL;
                        default: begin
                            reg_dst   = 1'b0;
                            reg_write = 1'b0;
                        end
                    endcase
                end
            end
            OP_ADDI: begin
                alu_src   = 1'b1;
                reg_write = 1'b1;
                sign_ext  = 1'b1;
            end
            OP_SLTI: begin
                alu_src     = 1'b1;
                reg_write   = 1'b1;
                sign_ext    = 1'b1;
                alu_control = ALU_SLT;
            end
            OP_ANDI: begin
                alu_src     = 1'b1;
                reg_write   = 1'b1;
                alu_control = ALU_AND;
            end
            OP_ORI: begin
                alu_src     = 1'b1;
                reg_write   = 1'b1;
                alu_control = ALU_OR;
            end
            OP_LW: begin
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                sign_ext   = 1'b1;
            end
            OP_SW: begin
                alu_src   = 1'b1;
                mem_write = 1'b1;
                sign_ext  = 1'b1;
            end
            OP_BEQ: begin
                beq         = 1'b1;
                sign_ext    = 1'b1;
                alu_control = ALU_SUB;
            end
            OP_BNE: begin
                bne         = 1'b1;
                sign_ext    = 1'b1;
                alu_control = ALU_SUB;
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump      = 1'b1;
                jal       = 1'b1;
                reg_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next-PC selection; all adds wrap modulo 2^13.
    assign pc_plus1      = pc + 13'd1;
    assign branch_target = 13'($signed(pc_plus1) + imm13);
    assign take_branch   = (beq & zero_flag) | (bne & ~zero_flag);

    always_comb begin
        next_pc = pc_plus1;
        if (jr) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = instr[12:0];
        end else if (take_branch) begin
            next_pc = branch_target;
        end
    end

    // PC register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= 13'h0000;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_control_pc_unit.sv
// Directed bench for control_pc_unit: decode outputs checked combinationally,
// PC progression checked through a queue of expected post-edge values.
module tb_control_pc_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        zero_flag;
    logic [12:0] rs_data;
    logic [12:0] pc;
    logic [12:0] pc_plus1;
    logic [12:0] branch_target;
    logic [12:0] next_pc;
    logic [3:0]  alu_control;
    logic        alu_src, reg_dst, mem_write, mem_read, beq, bne, jump;
    logic        mem_to_reg, reg_write, jr, jal, sign_ext;

    int          n_compared;
    int          n_failed;
    logic [12:0] exp_pc_q[$];
    logic [12:0] model_pc;

    control_pc_unit dut (
        .clk(clk), .reset(reset), .instr(instr), .zero_flag(zero_flag),
        .rs_data(rs_data), .pc(pc), .pc_plus1(pc_plus1),
        .branch_target(branch_target), .next_pc(next_pc),
        .alu_control(alu_control), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_write(mem_write), .mem_read(mem_read), .beq(beq), .bne(bne),
        .jump(jump), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .jr(jr), .jal(jal), .sign_ext(sign_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control word: {alu_control, alu_src, reg_dst, mem_write, mem_read,
    // beq, bne, jump, mem_to_reg, reg_write, jr, jal, sign_ext}.
    localparam logic [15:0] C_NOP  = 16'b0010_0000_0000_0000;
    localparam logic [15:0] C_LW   = 16'b0010_1001_0001_1001;
    localparam logic [15:0] C_SW   = 16'b0010_1010_0000_0001;
    localparam logic [15:0] C_BEQ  = 16'b0110_0000_1000_0001;
    localparam logic [15:0] C_BNE  = 16'b0110_0000_0100_0001;
    localparam logic [15:0] C_J    = 16'b0010_0000_0010_0000;
    localparam logic [15:0] C_JAL  = 16'b0010_0000_0010_1010;
    localparam logic [15:0] C_JR   = 16'b0010_0000_0000_0100;
    localparam logic [15:0] C_ADDI = 16'b0010_1000_0000_1001;
    localparam logic [15:0] C_SLTI = 16'b0111_1000_0000_1001;
    localparam logic [15:0] C_ANDI = 16'b0000_1000_0000_1000;
    localparam logic [15:0] C_ORI  = 16'b0001_1000_0000_1000;

    function automatic logic [15:0] rtype_ctl(input logic [3:0] alu);
        return {alu, 12'b0100_0000_1000};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one instruction, check decode and next_pc, then queue and retire the PC update.
    task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                        input logic zf, input logic [12:0] rs,
                        input logic [15:0] exp_ctl, input logic [12:0] exp_next,
                        input logic chk_bt, input logic [12:0] exp_bt);
        logic [12:0] popped;
        reset     = rst;
        instr     = ins;
        zero_flag = zf;
        rs_data   = rs;
        #1;
        check({tag, ".ctl"}, {alu_control, alu_src, reg_dst, mem_write, mem_read,
              beq, bne, jump, mem_to_reg, reg_write, jr, jal, sign_ext}, exp_ctl);
        check({tag, ".pc_plus1"}, {3'b0, pc_plus1}, {3'b0, 13'(model_pc + 13'd1)});
        if (!rst) check({tag, ".next_pc"}, {3'b0, next_pc}, {3'b0, exp_next});
        if (chk_bt) check({tag, ".branch_target"}, {3'b0, branch_target}, {3'b0, exp_bt});
        exp_pc_q.push_back(rst ? 13'h0000 : exp_next);
        @(posedge clk);
        #1;
        popped = exp_pc_q.pop_front();
        check({tag, ".pc"}, {3'b0, pc}, {3'b0, popped});
        model_pc = popped;
        @(negedge clk);
    endtask

    logic [31:0] fn_instr[8];
    logic [3:0]  fn_alu[8];

    initial begin
        n_compared = 0;
        n_failed   = 0;
        model_pc   = 13'h0000;
        reset      = 1'b1;
        instr      = 32'h0;
        zero_flag  = 1'b0;
        rs_data    = 13'h0;
        fn_instr = '{32'h012A4020, 32'h012A4022, 32'h012A4024, 32'h012A4025,
                     32'h012A4027, 32'h012A402A, 32'h00094080, 32'h00094082};
        fn_alu   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                     4'b1100, 4'b0111, 4'b1000, 4'b1001};

        @(negedge clk);
        exp_pc_q.push_back(13'h0000);
        @(posedge clk);
        #1;
        check("reset.pc", {3'b0, pc}, {3'b0, exp_pc_q.pop_front()});
        model_pc = 13'h0000;
        @(negedge clk);

        step("nop1", 0, 32'h00000000, 0, 13'h0, rtype_ctl(4'b1000), 13'd1, 0, 13'd0);
        step("nop2", 0, 32'h00000000, 0, 13'h0, rtype_ctl(4'b1000), 13'd2, 0, 13'd0);
        step("nop3", 0, 32'h00000000, 0, 13'h0, rtype_ctl(4'b1000), 13'd3, 0, 13'd0);
        step("lw",   0, 32'h8C080004, 0, 13'h0, C_LW, 13'd4, 0, 13'd0);
        step("sw",   0, 32'hAC080004, 0, 13'h0, C_SW, 13'd5, 0, 13'd0);
        step("beq_taken",  0, 32'h1109FFFE, 1, 13'h0, C_BEQ, 13'd4, 1, 13'd4);
        step("jr_to5a",    0, 32'h01000008, 0, 13'd5, C_JR, 13'd5, 0, 13'd0);
        step("beq_not",    0, 32'h1109FFFE, 0, 13'h0, C_BEQ, 13'd6, 1, 13'd4);
        step("jr_to5b",    0, 32'h01000008, 0, 13'd5, C_JR, 13'd5, 0, 13'd0);
        step("bne_taken",  0, 32'h1509FFFE, 0, 13'h0, C_BNE, 13'd4, 1, 13'd4);
        step("jr_to5c",    0, 32'h01000008, 1, 13'd5, C_JR, 13'd5, 0, 13'd0);
        step("bne_not",    0, 32'h1509FFFE, 1, 13'h0, C_BNE, 13'd6, 1, 13'd4);
        step("jal",        0, 32'h0C000123, 0, 13'h0, C_JAL, 13'h0123, 0, 13'd0);
        step("jr_abc",     0, 32'h01000008, 0, 13'h0ABC, C_JR, 13'h0ABC, 0, 13'd0);
        step("jr_top",     0, 32'h01000008, 0, 13'h1FFF, C_JR, 13'h1FFF, 0, 13'd0);
        step("nop_wrap",   0, 32'h00000000, 0, 13'h0, rtype_ctl(4'b1000), 13'h0000, 0, 13'd0);
        step("andi",       0, 32'h3108FFFF, 0, 13'h0, C_ANDI, 13'd1, 0, 13'd0);
        step("ori",        0, 32'h3508FFFF, 0, 13'h0, C_ORI, 13'd2, 0, 13'd0);
        step("slti",       0, 32'h29080005, 0, 13'h0, C_SLTI, 13'd3, 0, 13'd0);
        step("addi",       0, 32'h21080005, 0, 13'h0, C_ADDI, 13'd4, 0, 13'd0);
        step("unknown_op", 0, 32'hFC000000, 1, 13'h1234, C_NOP, 13'd5, 0, 13'd0);
        step("unknown_fn", 0, 32'h012A4001, 0, 13'h0, C_NOP, 13'd6, 0, 13'd0);
        for (int i = 0; i < 8; i++) begin
            step($sformatf("rtype%0d", i), 0, fn_instr[i], 0, 13'h0,
                 rtype_ctl(fn_alu[i]), 13'(7 + i), 0, 13'd0);
        end
        step("j",          0, 32'h08000010, 0, 13'h0, C_J, 13'h0010, 0, 13'd0);
        step("reset_mid",  1, 32'h0C000123, 0, 13'h0, C_JAL, 13'h0000, 0, 13'd0);
        step("after_rst",  0, 32'h00000000, 0, 13'h0, rtype_ctl(4'b1000), 13'd1, 0, 13'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
